// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared pipeline types for the memory stage.
//   word_t      - 32-bit datapath word
//   regbits_t   - 5-bit register index
//   memtoreg_t  - write-back source select
//   mem_state_t - memory access unit controller states
//   wb_select() - write-back data mux (code 3 aliases the ALU result)
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic [1:0] {
        MTR_ALU = 2'd0,
        MTR_MEM = 2'd1,
        MTR_PC4 = 2'd2
    } memtoreg_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HALTED
    } mem_state_t;

    function automatic word_t wb_select(input logic [1:0] mtr,
                                        input word_t      alu_out,
                                        input word_t      dload,
                                        input word_t      pc_4);
        case (mtr)
            MTR_MEM: return dload;
            MTR_PC4: return pc_4;
            default: return alu_out;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// mem_access_if: bundle of every signal crossing the mem_access_unit boundary.
//   CLK          - clock input of the interface
//   modport unit - the memory stage's view (EX/MEM + cache response in, requests + WB out)
//   modport tb   - the mirrored view for whatever drives the stage
interface mem_access_if
    import cpu_types_pkg::*;
(
    input logic CLK
);
    logic        RST;
    logic        mem_MemRd;
    logic        mem_MemWr;
    word_t       mem_alu_out;
    word_t       mem_rdat2;
    logic        mem_RegWr;
    word_t       mem_wsel;
    logic [1:0]  mem_MemtoReg;
    word_t       mem_pc_4;
    logic        mem_halt;
    logic        dhit;
    word_t       dload;
    logic        dREN;
    logic        dWEN;
    word_t       daddr;
    word_t       dstore;
    logic        stall;
    logic        wb_RegWr;
    regbits_t    wb_wsel;
    word_t       wb_wdat;
    logic        wb_halt;
    logic        misalign;
    logic        bus_err;

    modport unit (
        input  CLK, RST, mem_MemRd, mem_MemWr, mem_alu_out, mem_rdat2, mem_RegWr,
               mem_wsel, mem_MemtoReg, mem_pc_4, mem_halt, dhit, dload,
        output dREN, dWEN, daddr, dstore, stall, wb_RegWr, wb_wsel, wb_wdat,
               wb_halt, misalign, bus_err
    );

    modport tb (
        input  CLK, dREN, dWEN, daddr, dstore, stall, wb_RegWr, wb_wsel, wb_wdat,
               wb_halt, misalign, bus_err,
        output RST, mem_MemRd, mem_MemWr, mem_alu_out, mem_rdat2, mem_RegWr,
               mem_wsel, mem_MemtoReg, mem_pc_4, mem_halt, dhit, dload
    );

endinterface

// File: rtl/mem_wb_latch.sv
// mem_wb_latch: integrated MEM/WB pipeline register.
//   clk, rst    - clock, synchronous active-high reset
//   bubble      - 1 = stage stalled; insert a bubble (no write, halt held)
//   kill        - suppress the register write for this instruction
//   misaligned  - current instruction is an ignored misaligned access
//   mem_RegWr, mem_wsel, wdat, mem_halt - values captured when not bubbling
//   wb_RegWr, wb_wsel, wb_wdat, wb_halt, misalign - registered outputs
module mem_wb_latch
    import cpu_types_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     bubble,
    input  logic     kill,
    input  logic     misaligned,
    input  logic     mem_RegWr,
    input  regbits_t mem_wsel,
    input  word_t    wdat,
    input  logic     mem_halt,
    output logic     wb_RegWr,
    output regbits_t wb_wsel,
    output word_t    wb_wdat,
    output logic     wb_halt,
    output logic     misalign
);

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_RegWr <= 1'b0;
            wb_wsel  <= '0;
            wb_wdat  <= '0;
            wb_halt  <= 1'b0;
            misalign <= 1'b0;
        end else if (bubble) begin
            // Destination and data are left as-is; only the write strobe matters.
            wb_RegWr <= 1'b0;
            misalign <= 1'b0;
        end else begin
            wb_RegWr <= mem_RegWr & ~kill;
            wb_wsel  <= mem_wsel;
            wb_wdat  <= wdat;
            wb_halt  <= wb_halt | mem_halt;
            misalign <= misaligned;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory stage of the 5-stage pipeline with integrated MEM/WB latch.
//   CLK, RST                       - clock, synchronous active-high reset
//   mem_*                          - EX/MEM register outputs (control, address, data)
//   dhit, dload                    - data-cache completion and load data
//   dREN, dWEN, daddr, dstore      - data-cache request (combinational)
//   stall                          - hold all upstream registers
//   wb_RegWr, wb_wsel, wb_wdat     - registered write-back to the register file
//   wb_halt                        - sticky registered halt
//   misalign                       - one-cycle pulse for an ignored misaligned access
//   bus_err                        - sticky request-timeout flag
module mem_access_unit
    import cpu_types_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 255,
    parameter word_t       BAD_WORD   = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        mem_MemRd,
    input  logic        mem_MemWr,
    input  logic [31:0] mem_alu_out,
    input  logic [31:0] mem_rdat2,
    input  logic        mem_RegWr,
    input  logic [31:0] mem_wsel,
    input  logic [1:0]  mem_MemtoReg,
    input  logic [31:0] mem_pc_4,
    input  logic        mem_halt,
    input  logic        dhit,
    input  logic [31:0] dload,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    output logic        stall,
    output logic        wb_RegWr,
    output logic [4:0]  wb_wsel,
    output logic [31:0] wb_wdat,
    output logic        wb_halt,
    output logic        misalign,
    output logic        bus_err
);

    localparam int unsigned    CW      = $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(WAIT_LIMIT);

    mem_state_t    state, state_next;
    logic [CW-1:0] cnt, cnt_next;

    logic  mem_req, aligned, running;
    logic  access, misaligned, timeout, stall_int;
    word_t wdat;
    logic  unused_wsel_hi;

    assign unused_wsel_hi = ^mem_wsel[31:5];

    assign mem_req    = mem_MemRd | mem_MemWr;
    assign aligned    = (mem_alu_out[1:0] == 2'b00);
    assign running    = (state != HALTED);
    assign access     = mem_req & aligned & running;
    assign misaligned = mem_req & ~aligned & running;
    assign timeout    = (state == WAIT) & (cnt == CNT_MAX) & ~dhit;
    assign stall_int  = (access & ~dhit & ~timeout) | (state == HALTED);

    // Requests and stall are forced low while reset is held so the cache and
    // upstream see a quiet stage even though the EX/MEM inputs may still be live.
    assign dREN   = ~RST & access & mem_MemRd;
    assign dWEN   = ~RST & access & mem_MemWr & ~mem_MemRd;
    assign stall  = ~RST & stall_int;
    assign daddr  = mem_alu_out;
    assign dstore = mem_rdat2;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Leaving IDLE/WAIT happens exactly when the stage stops stalling, so a halt
    // that shows up alongside a pending access is taken only once the access ends.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (stall_int) begin
                    state_next = WAIT;
                    cnt_next   = CW'(1);
                end else if (mem_halt) begin
                    state_next = HALTED;
                end
            end
            WAIT: begin
                if (stall_int) begin
                    cnt_next = cnt + CW'(1);
                end else begin
                    cnt_next   = '0;
                    state_next = mem_halt ? HALTED : IDLE;
                end
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bus_err <= 1'b0;
        end else if (timeout) begin
            bus_err <= 1'b1;
        end
    end

    assign wdat = timeout ? BAD_WORD : wb_select(mem_MemtoReg, mem_alu_out, dload, mem_pc_4);

    mem_wb_latch u_wb_latch (
        .clk        (CLK),
        .rst        (RST),
        .bubble     (stall_int),
        .kill       (misaligned | timeout),
        .misaligned (misaligned),
        .mem_RegWr  (mem_RegWr),
        .mem_wsel   (mem_wsel[4:0]),
        .wdat       (wdat),
        .mem_halt   (mem_halt),
        .wb_RegWr   (wb_RegWr),
        .wb_wsel    (wb_wsel),
        .wb_wdat    (wb_wdat),
        .wb_halt    (wb_halt),
        .misalign   (misalign)
    );

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: self-checking bench for mem_access_unit with a
// transaction-level reference model (stall count, request count and
// write-back result computed per instruction from the access rules).
module tb_mem_access_unit;
    import cpu_types_pkg::*;

    localparam int    WL  = 4;
    localparam word_t BAD = 32'hBAD1BAD1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    mem_access_if ifc (.CLK(clk));

    mem_access_unit #(.WAIT_LIMIT(WL), .BAD_WORD(BAD)) dut (
        .CLK          (ifc.CLK),
        .RST          (ifc.RST),
        .mem_MemRd    (ifc.mem_MemRd),
        .mem_MemWr    (ifc.mem_MemWr),
        .mem_alu_out  (ifc.mem_alu_out),
        .mem_rdat2    (ifc.mem_rdat2),
        .mem_RegWr    (ifc.mem_RegWr),
        .mem_wsel     (ifc.mem_wsel),
        .mem_MemtoReg (ifc.mem_MemtoReg),
        .mem_pc_4     (ifc.mem_pc_4),
        .mem_halt     (ifc.mem_halt),
        .dhit         (ifc.dhit),
        .dload        (ifc.dload),
        .dREN         (ifc.dREN),
        .dWEN         (ifc.dWEN),
        .daddr        (ifc.daddr),
        .dstore       (ifc.dstore),
        .stall        (ifc.stall),
        .wb_RegWr     (ifc.wb_RegWr),
        .wb_wsel      (ifc.wb_wsel),
        .wb_wdat      (ifc.wb_wdat),
        .wb_halt      (ifc.wb_halt),
        .misalign     (ifc.misalign),
        .bus_err      (ifc.bus_err)
    );

    int   errs   = 0;
    int   checks = 0;
    logic bus_err_m = 1'b0;
    logic halt_m    = 1'b0;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        ifc.mem_MemRd    = 1'b0;
        ifc.mem_MemWr    = 1'b0;
        ifc.mem_alu_out  = '0;
        ifc.mem_rdat2    = '0;
        ifc.mem_RegWr    = 1'b0;
        ifc.mem_wsel     = '0;
        ifc.mem_MemtoReg = 2'd0;
        ifc.mem_pc_4     = '0;
        ifc.mem_halt     = 1'b0;
        ifc.dhit         = 1'b0;
        ifc.dload        = '0;
    endtask

    // Apply one instruction and let it run to completion.
    // lat = cycles with dhit low before the hit; lat > WL means the cache never answers.
    task automatic run_instr(input logic rd, input logic wr, input logic regwr,
                             input logic halt_i, input word_t addr, input word_t sdata,
                             input word_t pc4, input word_t ld, input logic [4:0] wsel_i,
                             input logic [1:0] mtr, input int lat, input string tag,
                             output int nreq, output int nstall);
        logic  acc, mis, tmo, exp_regwr, seen_stall, done, exp_ren, exp_wen;
        word_t exp_wdat;
        int    exp_nstall;
        acc        = (rd | wr) && (addr % 4 == 0);
        mis        = (rd | wr) && (addr % 4 != 0);
        tmo        = acc && (lat > WL);
        exp_nstall = !acc ? 0 : ((lat > WL) ? WL : lat);
        exp_ren    = acc && rd;
        exp_wen    = acc && wr && !rd;
        if (tmo)            exp_wdat = BAD;
        else if (mtr == 1)  exp_wdat = ld;
        else if (mtr == 2)  exp_wdat = pc4;
        else                exp_wdat = addr;
        exp_regwr = regwr && !mis && !tmo;

        ifc.mem_MemRd    = rd;
        ifc.mem_MemWr    = wr;
        ifc.mem_alu_out  = addr;
        ifc.mem_rdat2    = sdata;
        ifc.mem_RegWr    = regwr;
        ifc.mem_wsel     = {27'($urandom()), wsel_i};
        ifc.mem_MemtoReg = mtr;
        ifc.mem_pc_4     = pc4;
        ifc.mem_halt     = halt_i;
        ifc.dload        = ld;

        nreq = 0; nstall = 0; done = 1'b0;
        for (int c = 0; c <= WL + 1 && !done; c++) begin
            ifc.dhit = acc && (c == lat);
            @(negedge clk);
            checks++;
            if (ifc.dREN !== exp_ren) begin
                errs++; $display("FAIL %s dREN cyc%0d got %b want %b", tag, c, ifc.dREN, exp_ren);
            end
            checks++;
            if (ifc.dWEN !== exp_wen) begin
                errs++; $display("FAIL %s dWEN cyc%0d got %b want %b", tag, c, ifc.dWEN, exp_wen);
            end
            checks++;
            if (ifc.stall !== (c < exp_nstall)) begin
                errs++; $display("FAIL %s stall cyc%0d got %b want %b", tag, c, ifc.stall, c < exp_nstall);
            end
            if (c == 0) begin
                checks++;
                if (ifc.daddr !== addr || ifc.dstore !== sdata) begin
                    errs++; $display("FAIL %s daddr/dstore got %h/%h want %h/%h", tag, ifc.daddr, ifc.dstore, addr, sdata);
                end
            end
            if (ifc.dREN === 1'b1 || ifc.dWEN === 1'b1) nreq++;
            seen_stall = ifc.stall;
            if (seen_stall === 1'b1) nstall++;
            @(posedge clk); #1;
            if (seen_stall !== 1'b1) begin
                done = 1'b1;
            end else begin
                checks++;
                if (ifc.wb_RegWr !== 1'b0) begin
                    errs++; $display("FAIL %s bubble wb_RegWr got %b want 0", tag, ifc.wb_RegWr);
                end
            end
        end
        ifc.dhit = 1'b0;
        checks++;
        if (!done) begin
            errs++; $display("FAIL %s stall_release got stuck want released within %0d cycles", tag, WL + 2);
        end

        bus_err_m = bus_err_m | tmo;
        halt_m    = halt_m | halt_i;
        checks++;
        if (ifc.wb_RegWr !== exp_regwr) begin
            errs++; $display("FAIL %s wb_RegWr got %b want %b", tag, ifc.wb_RegWr, exp_regwr);
        end
        checks++;
        if (ifc.wb_wsel !== wsel_i) begin
            errs++; $display("FAIL %s wb_wsel got %0d want %0d", tag, ifc.wb_wsel, wsel_i);
        end
        checks++;
        if (ifc.wb_wdat !== exp_wdat) begin
            errs++; $display("FAIL %s wb_wdat got %h want %h", tag, ifc.wb_wdat, exp_wdat);
        end
        checks++;
        if (ifc.misalign !== mis) begin
            errs++; $display("FAIL %s misalign got %b want %b", tag, ifc.misalign, mis);
        end
        checks++;
        if (ifc.bus_err !== bus_err_m) begin
            errs++; $display("FAIL %s bus_err got %b want %b", tag, ifc.bus_err, bus_err_m);
        end
        checks++;
        if (ifc.wb_halt !== halt_m) begin
            errs++; $display("FAIL %s wb_halt got %b want %b", tag, ifc.wb_halt, halt_m);
        end
    endtask

    task automatic check_all_zero(input string tag);
        logic [9:0] got;
        got = {ifc.wb_RegWr, |ifc.wb_wsel, |ifc.wb_wdat, ifc.wb_halt, ifc.misalign,
               ifc.bus_err, ifc.dREN, ifc.dWEN, ifc.stall, 1'b0};
        checks++;
        if (got !== '0) begin
            errs++; $display("FAIL %s outputs got %b want all 0 (RegWr,wsel,wdat,halt,mis,berr,REN,WEN,stall)", tag, got);
        end
    endtask

    task automatic test_reset();
        drive_idle();
        ifc.RST         = 1'b1;
        ifc.mem_MemRd   = 1'b1;
        ifc.mem_alu_out = 32'h100;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        drive_idle();
        ifc.RST = 1'b0;
        bus_err_m = 1'b0; halt_m = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_load();
        int nreq, nstall;
        run_instr(1, 0, 1, 0, 32'h100, 32'h0, 32'h0, 32'hDEADBEEF, 5'd5, 2'd1, 2, "load", nreq, nstall);
        checks++;
        if (nreq != 3 || nstall != 2) begin
            errs++; $display("FAIL load_counts got req=%0d stall=%0d want req=3 stall=2", nreq, nstall);
        end
    endtask

    task automatic test_store();
        int nreq, nstall;
        run_instr(0, 1, 0, 0, 32'h204, 32'h1234, 32'h0, 32'h0, 5'd9, 2'd0, 0, "store", nreq, nstall);
        checks++;
        if (nreq != 1 || nstall != 0) begin
            errs++; $display("FAIL store_counts got req=%0d stall=%0d want req=1 stall=0", nreq, nstall);
        end
        run_instr(1, 1, 1, 0, 32'h208, 32'h55, 32'h0, 32'hCAFE0001, 5'd3, 2'd1, 1, "rd_and_wr", nreq, nstall);
    endtask

    task automatic test_misalign();
        int nreq, nstall;
        run_instr(1, 0, 1, 0, 32'h102, 32'h0, 32'h0, 32'h11111111, 5'd7, 2'd1, 0, "misalign", nreq, nstall);
        checks++;
        if (nreq != 0 || nstall != 0) begin
            errs++; $display("FAIL misalign_counts got req=%0d stall=%0d want 0/0", nreq, nstall);
        end
        run_instr(0, 0, 1, 0, 32'h77, 32'h0, 32'h0, 32'h0, 5'd8, 2'd0, 0, "after_misalign", nreq, nstall);
    endtask

    task automatic test_timeout();
        int nreq, nstall;
        run_instr(1, 0, 1, 0, 32'h300, 32'h0, 32'h0, 32'h22222222, 5'd6, 2'd1, WL + 1, "timeout", nreq, nstall);
        checks++;
        if (nreq != WL + 1 || nstall != WL) begin
            errs++; $display("FAIL timeout_counts got req=%0d stall=%0d want req=%0d stall=%0d", nreq, nstall, WL + 1, WL);
        end
        run_instr(0, 0, 1, 0, 32'h1234ABCD, 32'h0, 32'h0, 32'h0, 5'd10, 2'd3, 0, "after_timeout", nreq, nstall);
        run_instr(1, 0, 1, 0, 32'h304, 32'h0, 32'h0, 32'h33333333, 5'd11, 2'd1, WL, "hit_at_limit", nreq, nstall);
    endtask

    task automatic test_random();
        int nreq, nstall;
        for (int i = 0; i < 40; i++) begin
            int    kind;
            logic  rd, wr;
            word_t addr;
            kind = int'($urandom_range(0, 3));
            rd   = (kind == 0) || (kind == 3);
            wr   = (kind == 1) || (kind == 3);
            addr = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 4) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            run_instr(rd, wr, 1'($urandom()), 0, addr, $urandom(), $urandom(), $urandom(),
                      5'($urandom()), 2'($urandom()), int'($urandom_range(0, WL + 1)),
                      "random", nreq, nstall);
        end
    endtask

    task automatic test_reset_midwait();
        int nreq, nstall;
        ifc.mem_MemRd    = 1'b1;
        ifc.mem_alu_out  = 32'h400;
        ifc.mem_RegWr    = 1'b1;
        ifc.mem_wsel     = 32'd12;
        ifc.mem_MemtoReg = 2'd1;
        ifc.dload        = 32'h44444444;
        ifc.dhit         = 1'b0;
        @(negedge clk);
        checks++;
        if (ifc.stall !== 1'b1) begin
            errs++; $display("FAIL midwait_start stall got %b want 1", ifc.stall);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        ifc.RST = 1'b1;
        @(posedge clk); #1;
        check_all_zero("reset_midwait");
        ifc.RST = 1'b0;
        drive_idle();
        bus_err_m = 1'b0; halt_m = 1'b0;
        @(negedge clk);
        checks++;
        if (ifc.stall !== 1'b0 || ifc.dREN !== 1'b0) begin
            errs++; $display("FAIL after_reset stall/dREN got %b/%b want 0/0", ifc.stall, ifc.dREN);
        end
        @(posedge clk); #1;
        run_instr(1, 0, 1, 0, 32'h408, 32'h0, 32'h0, 32'h55555555, 5'd13, 2'd1, 1, "post_reset_load", nreq, nstall);
    endtask

    task automatic test_halt();
        int nreq, nstall;
        run_instr(0, 0, 1, 0, 32'h9999, 32'h0, 32'h40, 32'h0, 5'd31, 2'd2, 0, "jal", nreq, nstall);
        run_instr(0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 2'd0, 0, "halt", nreq, nstall);
        ifc.mem_halt  = 1'b0;
        ifc.mem_MemRd = 1'b1;
        ifc.mem_RegWr = 1'b1;
        ifc.mem_alu_out = 32'h500;
        ifc.dhit      = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (ifc.stall !== 1'b1 || ifc.dREN !== 1'b0 || ifc.dWEN !== 1'b0) begin
                errs++; $display("FAIL halted cyc%0d stall/dREN/dWEN got %b/%b/%b want 1/0/0", i, ifc.stall, ifc.dREN, ifc.dWEN);
            end
            @(posedge clk); #1;
            checks++;
            if (ifc.wb_RegWr !== 1'b0 || ifc.wb_halt !== 1'b1) begin
                errs++; $display("FAIL halted_wb cyc%0d RegWr/halt got %b/%b want 0/1", i, ifc.wb_RegWr, ifc.wb_halt);
            end
        end
        drive_idle();
        ifc.RST = 1'b1;
        @(posedge clk); #1;
        check_all_zero("reset_from_halt");
        ifc.RST = 1'b0;
        halt_m = 1'b0; bus_err_m = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        ifc.RST = 1'b1;
        drive_idle();
        test_reset();
        test_load();
        test_store();
        test_misalign();
        test_timeout();
        test_random();
        test_reset_midwait();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
